// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, bit timing
// constants and the parity helper.
package uart_pkg;

    localparam int TICKS_PER_BIT  = 16;
    localparam int HALF_BIT_TICKS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } tx_state_e;

    // Only the 5+dls transmitted bits take part; eps=0 inverts for odd parity.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] dls,
                                         input logic       eps);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - dls);
        return (^(data & mask)) ^ ~eps;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divisor: one-cycle tick every `divisor` clocks, silent while divisor=0.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst_b,
    input  logic [15:0] divisor,
    input  logic        set_vld,
    output logic        tick
);

    logic [15:0] cnt_d, cnt_q;
    logic        tick_d, tick_q;

    // The >= compare lets a shrinking divisor wrap immediately instead of
    // running the counter all the way round.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (set_vld || divisor == 16'd0) begin
            cnt_d = '0;
        end else if (cnt_q >= divisor - 16'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frame FSM, data shifter and parity generation,
// paced by the 16x tick from uart_baud_gen.
module uart_tx_ctrl
    import uart_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst_b,
    input  logic [15:0] reg_ctrl_dllh_data,
    input  logic        reg_ctrl_set_dllh_vld,
    input  logic [1:0]  reg_ctrl_lcr_dls,
    input  logic        reg_ctrl_lcr_pen,
    input  logic        reg_ctrl_lcr_eps,
    input  logic        reg_ctrl_lcr_stop,
    input  logic        reg_ctrl_thr_vld,
    input  logic [7:0]  reg_ctrl_thr_data,
    output logic        ctrl_reg_thr_read,
    output logic        ctrl_reg_thsr_empty,
    output logic        ctrl_reg_busy,
    output logic        uart_txd,
    output logic        tx_baud_tick
);

    localparam logic [3:0] FULL_LAST = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] HALF_LAST = 4'(HALF_BIT_TICKS - 1);

    logic baud_tick;

    uart_baud_gen u_baud_gen (
        .sys_clk (sys_clk),
        .rst_b   (rst_b),
        .divisor (reg_ctrl_dllh_data),
        .set_vld (reg_ctrl_set_dllh_vld),
        .tick    (baud_tick)
    );

    tx_state_e  state_d, state_q;
    logic [3:0] phase_d, phase_q;
    logic [2:0] bit_cnt_d, bit_cnt_q;
    logic [7:0] shift_d, shift_q;
    logic [1:0] dls_d, dls_q;
    logic       pen_d, pen_q;
    logic       stop_d, stop_q;
    logic       parity_d, parity_q;
    logic       txd_d, txd_q;
    logic       thr_read_d, thr_read_q;
    logic       empty_d, empty_q;
    logic       busy_d, busy_q;
    logic       bit_end, frame_done, load, can_load;
    logic [3:0] bit_last;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        dls_d      = dls_q;
        pen_d      = pen_q;
        stop_d     = stop_q;
        parity_d   = parity_q;
        thr_read_d = 1'b0;
        frame_done = 1'b0;
        load       = 1'b0;
        can_load   = reg_ctrl_thr_vld && (reg_ctrl_dllh_data != 16'd0);
        bit_last   = (state_q == ST_STOP2 && dls_q == 2'd0) ? HALF_LAST : FULL_LAST;
        bit_end    = baud_tick && (state_q != ST_IDLE) && (phase_q == bit_last);

        if (baud_tick && state_q != ST_IDLE) begin
            phase_d = bit_end ? 4'd0 : phase_q + 4'd1;
        end

        case (state_q)
            ST_IDLE:   load = can_load;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == ({1'b0, dls_q} + 3'd4)) begin
                        state_d = pen_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP1;
            ST_STOP1: begin
                if (bit_end) begin
                    if (stop_q) state_d = ST_STOP2;
                    else        frame_done = 1'b1;
                end
            end
            ST_STOP2:  frame_done = bit_end;
            default:   state_d = ST_IDLE;
        endcase

        // A waiting byte chains straight into the next START with no idle bit.
        if (frame_done) begin
            if (can_load) load = 1'b1;
            else          state_d = ST_IDLE;
        end

        if (load) begin
            state_d    = ST_START;
            shift_d    = reg_ctrl_thr_data;
            dls_d      = reg_ctrl_lcr_dls;
            pen_d      = reg_ctrl_lcr_pen;
            stop_d     = reg_ctrl_lcr_stop;
            parity_d   = calc_parity(reg_ctrl_thr_data, reg_ctrl_lcr_dls, reg_ctrl_lcr_eps);
            phase_d    = 4'd0;
            bit_cnt_d  = 3'd0;
            thr_read_d = 1'b1;
        end

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = parity_d;
            default:   txd_d = 1'b1;
        endcase

        empty_d = (state_d == ST_IDLE);
        busy_d  = ~empty_d;
    end

    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            dls_q      <= '0;
            pen_q      <= 1'b0;
            stop_q     <= 1'b0;
            parity_q   <= 1'b0;
            txd_q      <= 1'b1;
            thr_read_q <= 1'b0;
            empty_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            dls_q      <= dls_d;
            pen_q      <= pen_d;
            stop_q     <= stop_d;
            parity_q   <= parity_d;
            txd_q      <= txd_d;
            thr_read_q <= thr_read_d;
            empty_q    <= empty_d;
            busy_q     <= busy_d;
        end
    end

    assign uart_txd            = txd_q;
    assign ctrl_reg_thr_read   = thr_read_q;
    assign ctrl_reg_thsr_empty = empty_q;
    assign ctrl_reg_busy       = busy_q;
    assign tx_baud_tick        = baud_tick;

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- sys_clk  in  1  system clock.
- rst_b  in  1  asynchronous active-low reset.
- reg_ctrl_dllh_data  in  16  baud divisor {DLH,DLL}.
- reg_ctrl_set_dllh_vld  in  1  divisor write strobe.
- reg_ctrl_lcr_dls  in  2  data length minus 5.
- reg_ctrl_lcr_pen  in  1  parity enable.
- reg_ctrl_lcr_eps  in  1  1 = even parity, 0 = odd parity.
- reg_ctrl_lcr_stop  in  1  0 = 1 stop bit, 1 = 2 stop bits (1.5 when dls=0).
- reg_ctrl_thr_vld  in  1  THR holds a byte.
- reg_ctrl_thr_data  in  8  THR byte.
- ctrl_reg_thr_read  out  1  one-cycle pulse, THR consumed.
- ctrl_reg_thsr_empty  out  1  shifter idle.
- ctrl_reg_busy  out  1  frame in progress.
- uart_txd  out  1  serial output, idle high.
- tx_baud_tick  out  1  16x oversample tick.

REQ-002 SHALL use reset rst_b (asynchronous, active-low) and clock sys_clk.

Function
REQ-003 SHALL run a divisor counter on sys_clk that pulses tx_baud_tick for one cycle every D cycles, where D = reg_ctrl_dllh_data.
REQ-004 SHALL produce no ticks while D=0 and SHALL remain in IDLE (or hold the current state) in that case.
REQ-005 SHALL clear the divisor counter on reg_ctrl_set_dllh_vld; a frame in progress continues at the new rate.
REQ-006 SHALL implement the states IDLE, START, DATA, PARITY, STOP1 and STOP2; each bit lasts 16 ticks except STOP2 in 1.5-stop mode, which lasts 8 ticks.
REQ-007 In IDLE, when reg_ctrl_thr_vld=1 and D≠0, SHALL on the next edge enter START, load reg_ctrl_thr_data into the shifter, snapshot dls/pen/eps/stop, reset the tick-phase counter, and assert ctrl_reg_thr_read for exactly that one cycle.
REQ-008 SHALL drive uart_txd as follows:
- START: 0.
- DATA: shifter LSB first, 5+dls bits.
- PARITY: parity bit, present only when pen=1.
- STOP1/STOP2 and IDLE: 1.
REQ-009 The parity bit SHALL equal the XOR of the transmitted data bits when eps=1, and its inverse when eps=0.
REQ-010 SHALL enter STOP2 only when stop=1.
REQ-011 At the end of the last stop bit, if thr_vld=1 the block SHALL go directly to START using the REQ-007 actions (no idle bit); otherwise it SHALL return to IDLE.
REQ-012 Changes to LCR during a frame (including reg_ctrl_lcr_wen) SHALL NOT affect the current frame; they apply from the next frame.
REQ-013 SHALL assert ctrl_reg_thsr_empty exactly when the state is IDLE; ctrl_reg_busy SHALL equal its inverse.
REQ-014 SHALL register all outputs; uart_txd SHALL be glitch-free.

Reset
REQ-015 On reset the block SHALL be in IDLE with uart_txd=1, ctrl_reg_thsr_empty=1, ctrl_reg_busy=0, ctrl_reg_thr_read=0, tx_baud_tick=0, and all counters and the shifter at 0.
REQ-016 Reset asserted mid-frame SHALL abort the frame immediately (uart_txd=1 asynchronously), and the byte SHALL NOT be retransmitted.

Structure
REQ-017 A shared package uart_pkg SHALL hold the state enumeration, TICKS_PER_BIT=16 and HALF_BIT_TICKS=8.
REQ-018 The baud generator (REQ-003..005) SHALL be the sub-module uart_baud_gen; the FSM, shifter and parity logic SHALL remain in uart_tx_ctrl.

Verification
REQ-019 D=1, dls=3, pen=0, stop=0, THR=0x55:
- thr_read pulses once;
- uart_txd = 0,1,0,1,0,1,0,1,0,1 then 1, each level 16 clocks;
- busy is high for 160 clocks.
REQ-020 D=2, dls=2, pen=1, eps=1, THR=0x41 (7 bits): frame = start, 1000001, parity 0, stop; each bit 32 clocks.
REQ-021 D=1, dls=0, stop=1: stop period is 24 ticks; with dls=3 and stop=1 it is 32 ticks.
REQ-022 Back-to-back: THR is rewritten during the stop bit of the previous byte; START begins on the cycle after the stop bit ends, with no idle bit; exactly 2 thr_read pulses in total.
REQ-023 D=0 with thr_vld=1 gives no thr_read and uart_txd stays 1.
REQ-024 Reset pulse at DATA bit 3 gives an immediate IDLE/txd=1; pen change mid-frame alters only the next frame.
